// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared constants and FSM state type for the time-shared soft LUT
package lut_pkg;

    localparam int LUT_W  = 16;
    localparam int OPND_W = 4;

    localparam logic [LUT_W-1:0] DEF_INIT_TBL = 16'h8888;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CFG  = 2'd2
    } state_t;

endpackage

// File: rtl/lut_share_sched_rr_arbiter.sv
// rtl/lut_share_sched_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest match is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/lut_share_sched.sv
// rtl/lut_share_sched.sv - round-robin scheduler sharing one programmable 4-input LUT among requesters
module lut_share_sched
    import lut_pkg::*;
#(
    parameter int               N_REQ    = 4,
    parameter int               IDX_W    = 2,
    parameter logic [LUT_W-1:0] INIT_TBL = DEF_INIT_TBL
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cfg_we,
    input  logic [LUT_W-1:0]        cfg_data,
    output logic                    cfg_busy,
    input  logic [N_REQ-1:0]        req,
    input  logic [OPND_W*N_REQ-1:0] opnd,
    output logic [N_REQ-1:0]        ack,
    output logic                    result,
    output logic [IDX_W-1:0]        result_id,
    output logic [LUT_W-1:0]        table_q
);

    state_t state, next_state;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  g_q;
    logic [OPND_W-1:0] opnd_q;
    logic [LUT_W-1:0]  cfg_q;

    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_load;
    logic              eval_fire;
    logic              cfg_apply;

    logic [OPND_W-1:0] opnd_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_opnd
        assign opnd_arr[i] = opnd[OPND_W*i +: OPND_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // cfg_busy doubles as the "config pending" flag, so a write latched during EVAL wins the next IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cfg_we || cfg_busy) next_state = CFG;
                else if (grant_valid)   next_state = EVAL;
            end
            EVAL:    next_state = IDLE;
            CFG:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant_load = (state == IDLE) && !(cfg_we || cfg_busy) && grant_valid;
        eval_fire  = (state == EVAL);
        cfg_apply  = (state == CFG);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            table_q   <= INIT_TBL;
            ack       <= '0;
            result    <= 1'b0;
            result_id <= '0;
            cfg_busy  <= 1'b0;
            ptr       <= '0;
            g_q       <= '0;
            opnd_q    <= '0;
            cfg_q     <= '0;
        end else begin
            ack <= '0;
            if (grant_load) begin
                g_q    <= grant_idx;
                opnd_q <= opnd_arr[grant_idx];
            end
            if (eval_fire) begin
                result    <= table_q[opnd_q];
                ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << g_q;
                result_id <= g_q;
                ptr       <= (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
            end
            // A write landing on the apply cycle is folded in so only one table update occurs.
            if (cfg_apply) begin
                table_q  <= cfg_we ? cfg_data : cfg_q;
                cfg_busy <= 1'b0;
            end else if (cfg_we) begin
                cfg_q    <= cfg_data;
                cfg_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lut_share_sched.sv
// tb/tb_lut_share_sched.sv - directed and random checks of lut_share_sched against a job-level reference model
module tb_lut_share_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [15:0] cfg_data;
    logic        cfg_busy;
    logic [3:0]  req;
    logic [15:0] opnd;
    logic [3:0]  ack;
    logic        result;
    logic [1:0]  result_id;
    logic [15:0] table_q;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: what job the block is doing, plus the architectural values.
    int          m_job;
    int          m_g;
    int          m_ptr;
    logic [3:0]  m_op;
    logic [15:0] m_tbl;
    logic [15:0] m_cfg;
    logic        m_busy;
    logic [3:0]  m_ack;
    logic        m_res;
    logic [1:0]  m_id;

    int got[$];

    always #5 clk = ~clk;

    lut_share_sched #(
        .N_REQ    (4),
        .IDX_W    (2),
        .INIT_TBL (16'h8888)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .req       (req),
        .opnd      (opnd),
        .ack       (ack),
        .result    (result),
        .result_id (result_id),
        .table_q   (table_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int g;
        if (rst) begin
            m_job = 0; m_ptr = 0; m_tbl = 16'h8888; m_cfg = '0; m_busy = 1'b0;
            m_ack = '0; m_res = 1'b0; m_id = '0;
        end else begin
            m_ack = '0;
            if (m_job == 1) begin
                m_res = m_tbl[m_op];
                m_ack = 4'(1 << m_g);
                m_id  = 2'(m_g);
                m_ptr = (m_g + 1) % N;
                if (cfg_we) begin m_cfg = cfg_data; m_busy = 1'b1; end
                m_job = 0;
            end else if (m_job == 2) begin
                m_tbl  = cfg_we ? cfg_data : m_cfg;
                m_busy = 1'b0;
                m_job  = 0;
            end else if (cfg_we || m_busy) begin
                if (cfg_we) m_cfg = cfg_data;
                m_busy = 1'b1;
                m_job  = 2;
            end else if (req != 0) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && ((req >> ((m_ptr + k) % N)) & 4'd1) != 0) g = (m_ptr + k) % N;
                m_g   = g;
                m_op  = 4'(opnd >> (4 * g));
                m_job = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("ack", 32'(ack), 32'(m_ack));
        check("result", 32'(result), 32'(m_res));
        check("result_id", 32'(result_id), 32'(m_id));
        check("table_q", 32'(table_q), 32'(m_tbl));
        check("cfg_busy", 32'(cfg_busy), 32'(m_busy));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_data = '0; req = '0; opnd = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_table", 32'(table_q), 32'h8888);
        check("reset_busy", 32'(cfg_busy), 32'h0);

        // 1: single request, ack two edges later
        req = 4'b0001; opnd = 16'h0003;
        tick();
        check("t1_no_early_ack", 32'(ack), 32'h0);
        tick();
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_result", 32'(result), 32'h1);
        check("t1_id", 32'(result_id), 32'h0);
        req = '0;
        tick();

        // 2: all requesting, round-robin from a fresh pointer
        do_reset();
        req = 4'b1111; opnd = 16'(($urandom));
        for (int i = 0; i < 16; i++) begin
            tick();
            if (ack != 0) got.push_back(int'(result_id));
            if (i % 2 == 0) check("t2_gap", 32'(ack), 32'h0);
        end
        req = '0;
        tick();
        check("t2_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size(); i++) check("t2_order", 32'(got[i]), 32'(i % 4));

        // 3: reprogram to XOR
        cfg_we = 1'b1; cfg_data = 16'h6666;
        tick();
        check("t3_busy", 32'(cfg_busy), 32'h1);
        cfg_we = 1'b0;
        tick();
        check("t3_table", 32'(table_q), 32'h6666);
        req = 4'b0001; opnd = 16'h0001;
        tick(); tick();
        check("t3_xor01", 32'(result), 32'h1);
        req = '0;
        tick();
        req = 4'b0001; opnd = 16'h0003;
        tick(); tick();
        check("t3_xor11", 32'(result), 32'h0);
        req = '0;
        tick();

        // 4: config wins over a simultaneous request, eval then uses the new table
        cfg_we = 1'b1; cfg_data = 16'h00F0; req = 4'b0010; opnd = 16'h0040;
        tick();
        cfg_we = 1'b0;
        tick(); tick(); tick();
        check("t4_ack", 32'(ack), 32'h2);
        check("t4_result", 32'(result), 32'h1);
        req = '0;
        tick();

        // 5: two writes around an eval collapse into one update
        req = 4'b0001; opnd = 16'h0005;
        tick();
        req = '0; cfg_we = 1'b1; cfg_data = 16'hFFFF;
        tick();
        check("t5_ack", 32'(ack), 32'h1);
        cfg_data = 16'h0000;
        tick();
        check("t5_no_ffff", 32'(table_q), 32'h00F0);
        cfg_we = 1'b0;
        tick();
        check("t5_table", 32'(table_q), 32'h0000);
        check("t5_busy", 32'(cfg_busy), 32'h0);
        tick();

        // 6: reset in EVAL aborts and clears the pointer
        req = 4'b0100; opnd = 16'h0300;
        tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        check("t6_no_ack", 32'(ack), 32'h0);
        check("t6_table", 32'(table_q), 32'h8888);
        tick();
        check("t6_still_no_ack", 32'(ack), 32'h0);
        req = 4'b0011; opnd = 16'h0033;
        tick(); tick();
        check("t6_ptr0", 32'(ack), 32'h1);
        req = '0;
        tick();
        req = 4'b1000; opnd = 16'h3000;
        tick(); tick();
        check("t6_ack3", 32'(ack), 32'h8);
        check("t6_res3", 32'(result), 32'h1);
        req = '0;
        tick();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req      = 4'($urandom);
            opnd     = 16'($urandom);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_data = 16'($urandom);
            rst      = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0; req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
